mem_access_master: RTL
======================

Name: mem_access_master

Overview:
- Initiator side of the unified instruction/data memory used by the multicycle MIPS core.
- Accepts one word request at a time (fetch, load or store) from the control unit over a valid/ready handshake.
- Checks alignment and region, then drives the memory system's address, write-enable and write-data lines, and captures the returned word.
- Returns data or an error over a valid/ready response handshake.

Parameters:
- DATA_WIDTH, 32, word and address width.
- MEMORY_DEPTH, 64, words per region; same value as the memory system instance.
- ROM_BASE, 32'h00400000, text region base; read-only.
- RAM_BASE, 32'h10100000, data region base; read/write.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid_i  input  1  request present.
- req_ready_o  output  1  block can accept a request.
- req_write_i  input  1  1 = store, 0 = read.
- req_addr_i  input  DATA_WIDTH  byte address.
- req_wdata_i  input  DATA_WIDTH  store data.
- rsp_valid_o  output  1  response present.
- rsp_ready_i  input  1  consumer takes the response.
- rsp_rdata_o  output  DATA_WIDTH  read data; 0 for stores and errors.
- rsp_err_o  output  1  request rejected.
- mem_we_o  output  1  to memory Write_Enable_i.
- mem_addr_o  output  DATA_WIDTH  to memory Address_i.
- mem_wdata_o  output  DATA_WIDTH  to memory Write_Data.
- mem_rdata_i  input  DATA_WIDTH  from memory Instruction_o.
- rd_count_o  output  16  completed good reads (see Optional Feature).
- wr_count_o  output  16  completed good stores.
- err_count_o  output  16  error responses.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on the port named reset. It takes effect only on a rising clk edge.
- Reset values:
  - state IDLE, req_ready_o=1, rsp_valid_o=0.
  - rsp_rdata_o=0, rsp_err_o=0.
  - mem_we_o=0, mem_addr_o=ROM_BASE, mem_wdata_o=0.
  - all counters 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - req_ready_o=1 only in IDLE.
  - On req_valid_i=1, latch write, addr and wdata, then classify the request.
  - Legal: go to ISSUE.
  - Illegal: go directly to RESP with rsp_err_o=1 and rsp_rdata_o=0. Memory lines are untouched and mem_we_o stays 0.
- Illegal request conditions:
  - addr[1:0] != 0.
  - addr outside both [ROM_BASE, ROM_BASE+4*MEMORY_DEPTH) and [RAM_BASE, RAM_BASE+4*MEMORY_DEPTH). Use unsigned compares; the upper bounds are exclusive.
  - write=1 to the ROM region.
- ISSUE (one cycle):
  - mem_addr_o = latched address.
  - mem_we_o = latched write.
  - mem_wdata_o = latched wdata.
- WAIT (one cycle):
  - mem_addr_o held, mem_we_o=0.
  - The RAM read is registered, so data is valid after the ISSUE edge.
  - At the end of WAIT, read requests load mem_rdata_i into rsp_rdata_o; stores load 0.
  - Both regions use the same path, so the latency is uniform.
- RESP:
  - rsp_valid_o=1; rsp_rdata_o and rsp_err_o stay stable.
  - On rsp_ready_i=1, return to IDLE and clear rsp_valid_o at that edge.
  - A new request cannot be accepted in the same cycle; the next one is accepted one cycle later.
- Latency, counted from the accept edge (cycle 0):
  - legal request: rsp_valid_o in cycle 3.
  - error: rsp_valid_o in cycle 1.
  - Throughput: one request per 4 cycles minimum.
- Held bus: outside ISSUE and WAIT, mem_addr_o keeps its last value and mem_we_o=0. mem_we_o is never high for more than one cycle per store.
- Input changes: req_* changes while not in IDLE are ignored.
- Reset mid-operation: at the reset edge, go to IDLE and force mem_we_o=0. Any in-flight request is dropped with no response. A store whose ISSUE cycle already completed has been written.

Optional Feature:
- Macro: MEM_ACCESS_COUNTERS_EN.
- Defined:
  - rd_count_o increments when a legal read leaves RESP.
  - wr_count_o increments when a legal store leaves RESP.
  - err_count_o increments when an error response leaves RESP.
  - Counters are 16-bit, wrap at 16'hFFFF to 0, and are cleared by reset.
- Not defined: the three ports remain and are tied to 0; no counter flops are generated.

Test Plan:
- Store then load RAM: write 0x10100008 with 0xDEADBEEF, rsp_ready_i=1. Expect one mem_we_o pulse in cycle 1 and response err=0, rdata=0 in cycle 3. Then read 0x10100008: rdata=0xDEADBEEF in cycle 3.
- ROM fetch: read 0x00400004. mem_addr_o=0x00400004 in cycles 1-2; rsp_rdata_o equals ROM word 1 from the loaded image; err=0.
- Errors:
  - read 0x10100002: err=1 in cycle 1, rdata=0, mem_we_o never asserted.
  - write 0x00400000: err=1.
  - read 0x10100100 (word 64, out of range): err=1.
- Backpressure: hold rsp_ready_i=0 for 5 cycles after rsp_valid_o. Response stays stable, req_ready_o=0, and a second req_valid_i is ignored until RESP exits.
- Reset mid-op: assert reset in the WAIT cycle of a read. Next cycle shows IDLE, req_ready_o=1, rsp_valid_o=0, mem_we_o=0, and no response is ever produced.
- With MEM_ACCESS_COUNTERS_EN: 2 reads, 1 store, 1 error gives rd=2, wr=1, err=1. Without the macro, all three counters read 0.

Source files
------------

// File: rtl/mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master
// Purpose  : Initiator side of the unified instruction/data memory of the
//            multicycle MIPS core. Takes one word request (fetch, load or
//            store) at a time, checks alignment and region, drives the memory
//            address / write-enable / write-data lines, captures the returned
//            word and hands back data or an error.
// Ports    : clk, reset             - clock, synchronous active-high reset
//            req_valid_i/ready_o    - request handshake
//            req_write_i/addr_i/wdata_i - request payload
//            rsp_valid_o/ready_i    - response handshake
//            rsp_rdata_o/err_o      - response payload
//            mem_we_o/addr_o/wdata_o, mem_rdata_i - memory system side
//            rd_count_o/wr_count_o/err_count_o    - activity counters
// Options  : MEM_ACCESS_COUNTERS_EN - when defined, the three counters are
//            live; otherwise they are tied to 0 and no counter flops exist.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_master #(
  parameter int                    DATA_WIDTH   = 32,
  parameter int                    MEMORY_DEPTH = 64,
  parameter logic [DATA_WIDTH-1:0] ROM_BASE     = 32'h00400000,
  parameter logic [DATA_WIDTH-1:0] RAM_BASE     = 32'h10100000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [15:0]           rd_count_o,
  output logic [15:0]           wr_count_o,
  output logic [15:0]           err_count_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [DATA_WIDTH-1:0] REGION_BYTES = DATA_WIDTH'(4 * MEMORY_DEPTH);

  logic [1:0]            state_q, state_d;
  logic                  write_q;
  logic                  rsp_err_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  mem_we_q;
  logic [DATA_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;

  // Offset-from-base compares give an unsigned [base, base+size) window
  // with a single comparator per region.
  logic [DATA_WIDTH-1:0] rom_off, ram_off;
  logic                  in_rom, in_ram, req_legal;

  assign rom_off   = req_addr_i - ROM_BASE;
  assign ram_off   = req_addr_i - RAM_BASE;
  assign in_rom    = rom_off < REGION_BYTES;
  assign in_ram    = ram_off < REGION_BYTES;
  assign req_legal = (req_addr_i[1:0] == 2'b00) && (in_ram || (in_rom && !req_write_i));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid_i) state_d = req_legal ? S_ISSUE : S_RESP;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  state_d = S_RESP;
      S_RESP:  if (rsp_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      write_q     <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= ROM_BASE;
      mem_wdata_q <= '0;
    end else begin
      state_q  <= state_d;
      // Write enable is loaded only at the accept edge, so it is high for
      // exactly the ISSUE cycle and low everywhere else.
      mem_we_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            write_q <= req_write_i;
            if (req_legal) begin
              mem_addr_q  <= req_addr_i;
              mem_we_q    <= req_write_i;
              mem_wdata_q <= req_wdata_i;
              rsp_err_q   <= 1'b0;
            end else begin
              // Rejected requests leave the memory bus untouched.
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        // Memory read is registered: the word addressed in ISSUE is
        // presented during WAIT and captured at its closing edge.
        S_WAIT:  rsp_rdata_q <= write_q ? '0 : mem_rdata_i;
        default: ;
      endcase
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

`ifdef MEM_ACCESS_COUNTERS_EN
  logic [15:0] rd_count_q, wr_count_q, err_count_q;
  logic        rsp_done;

  assign rsp_done = (state_q == S_RESP) && rsp_ready_i;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count_q  <= '0;
      wr_count_q  <= '0;
      err_count_q <= '0;
    end else if (rsp_done) begin
      if (rsp_err_q)    err_count_q <= err_count_q + 16'd1;
      else if (write_q) wr_count_q  <= wr_count_q + 16'd1;
      else              rd_count_q  <= rd_count_q + 16'd1;
    end
  end

  assign rd_count_o  = rd_count_q;
  assign wr_count_o  = wr_count_q;
  assign err_count_o = err_count_q;
`else
  assign rd_count_o  = '0;
  assign wr_count_o  = '0;
  assign err_count_o = '0;
`endif

endmodule
`default_nettype wire
